// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types and response encodings used by the link endpoints.
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [1:0]        resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite interconnect bundle: AW/W/B/AR/R channels with master and slave views.
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t       awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  resp_t       bresp;
  logic        bvalid;
  logic        bready;
  addr_t       araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  resp_t       rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: converts single-beat client commands into one in-flight
// read or write transaction and hands the data/response back to the client.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  addr_t       cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output resp_t       rsp_resp,
  output logic        timeout_o,
  axi_lite_if.master  m_axi_lite
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RSP} state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  state_t            state, state_n;
  addr_t             addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [3:0]        wstrb_q, wstrb_n;
  logic              write_q, write_n;
  logic              awvalid_q, awvalid_n, wvalid_q, wvalid_n, arvalid_q, arvalid_n;
  logic              bready_q, bready_n, rready_q, rready_n;
  logic              aw_done_q, aw_done_n, w_done_q, w_done_n;
  logic [31:0]       rdata_q, rdata_n;
  resp_t             resp_q, resp_n;
  logic              timeout_q, timeout_n;
  logic [TO_W-1:0]   cnt_q, cnt_n;
  logic              aw_hs, w_hs, ar_hs, r_hs, b_hs;

  assign aw_hs = awvalid_q && m_axi_lite.awready;
  assign w_hs  = wvalid_q  && m_axi_lite.wready;
  assign ar_hs = arvalid_q && m_axi_lite.arready;
  assign r_hs  = rready_q  && m_axi_lite.rvalid;
  assign b_hs  = bready_q  && m_axi_lite.bvalid;

  // Every AXI-facing control is a register; this block only computes the next values.
  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    write_n   = write_q;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    arvalid_n = arvalid_q;
    bready_n  = bready_q;
    rready_n  = rready_q;
    aw_done_n = aw_done_q;
    w_done_n  = w_done_q;
    rdata_n   = rdata_q;
    resp_n    = resp_q;
    timeout_n = timeout_q;
    cnt_n     = cnt_q;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n    = cmd_addr;
          wdata_n   = cmd_wdata;
          wstrb_n   = cmd_wstrb;
          write_n   = cmd_write;
          cnt_n     = '0;
          timeout_n = 1'b0;
          if (cmd_write) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WRITE;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RADDR;
          end
        end
      end
      RADDR: begin
        if (ar_hs) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          rdata_n  = m_axi_lite.rdata;
          resp_n   = m_axi_lite.rresp;
          rready_n = 1'b0;
          state_n  = RSP;
        end
      end
      WRITE: begin
        if (aw_hs) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (w_hs) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_n = 1'b1;
          state_n  = WRESP;
        end
      end
      WRESP: begin
        if (b_hs) begin
          resp_n   = m_axi_lite.bresp;
          rdata_n  = '0;
          bready_n = 1'b0;
          state_n  = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Watchdog only observes; it never cancels the transaction in flight.
    if (state == RADDR || state == RDATA || state == WRITE || state == WRESP) begin
      if (aw_hs || w_hs || ar_hs || r_hs || b_hs) cnt_n = '0;
      else if (cnt_q != TO_MAX) cnt_n = cnt_q + 1'b1;
      if (cnt_n == TO_MAX) timeout_n = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      wstrb_q   <= wstrb_n;
      write_q   <= write_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      arvalid_q <= arvalid_n;
      bready_q  <= bready_n;
      rready_q  <= rready_n;
      aw_done_q <= aw_done_n;
      w_done_q  <= w_done_n;
      rdata_q   <= rdata_n;
      resp_q    <= resp_n;
      timeout_q <= timeout_n;
      cnt_q     <= cnt_n;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign timeout_o = timeout_q;

  assign m_axi_lite.awaddr  = addr_q;
  assign m_axi_lite.awprot  = 3'b000;
  assign m_axi_lite.awvalid = awvalid_q;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = wstrb_q;
  assign m_axi_lite.wvalid  = wvalid_q;
  assign m_axi_lite.bready  = bready_q;
  assign m_axi_lite.araddr  = addr_q;
  assign m_axi_lite.arprot  = 3'b000;
  assign m_axi_lite.arvalid = arvalid_q;
  assign m_axi_lite.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench: axi_lite_master driving a small behavioural AXI-Lite target
// whose ready lines and response code are steered from the stimulus sequence.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  addr_t       cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  resp_t       rsp_resp;
  logic        timeout_o;

  int compared   = 0;
  int mismatched = 0;

  axi_lite_if bus();

  axi_lite_master #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .timeout_o  (timeout_o),
    .m_axi_lite (bus)
  );

  always #5 aclk = ~aclk;

  // Target model: readies steered by the sequence, responses registered.
  logic        aw_rdy, w_rdy, ar_rdy;
  resp_t       slv_resp;
  logic        s_rvalid, s_bvalid, aw_got, w_got;
  logic [31:0] s_rdata, wdata_l;
  resp_t       s_rresp, s_bresp;
  addr_t       awaddr_l;
  logic [3:0]  wstrb_l;
  logic [31:0] mem [0:15];
  logic        aw_hs, w_hs, ar_hs, aw_have, w_have;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] merged;

  assign bus.awready = aw_rdy;
  assign bus.wready  = w_rdy;
  assign bus.arready = ar_rdy;
  assign bus.rvalid  = s_rvalid;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = s_rresp;
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;

  assign aw_hs   = bus.awvalid && aw_rdy;
  assign w_hs    = bus.wvalid && w_rdy;
  assign ar_hs   = bus.arvalid && ar_rdy;
  assign aw_have = aw_got || aw_hs;
  assign w_have  = w_got || w_hs;
  assign wr_idx  = aw_hs ? bus.awaddr[5:2] : awaddr_l[5:2];
  assign wr_data = w_hs ? bus.wdata : wdata_l;
  assign wr_strb = w_hs ? bus.wstrb : wstrb_l;

  always_comb begin
    merged = mem[wr_idx];
    for (int b = 0; b < 4; b++)
      if (wr_strb[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
  end

  always @(posedge aclk) begin
    if (!areset_n) begin
      s_rvalid <= 1'b0;
      s_bvalid <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
      s_bresp  <= RESP_OKAY;
      awaddr_l <= '0;
      wdata_l  <= '0;
      wstrb_l  <= '0;
    end else begin
      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[bus.araddr[5:2]];
        s_rresp  <= slv_resp;
      end else if (s_rvalid && bus.rready) begin
        s_rvalid <= 1'b0;
      end
      if (aw_have && w_have && !s_bvalid) begin
        mem[wr_idx] <= merged;
        s_bvalid    <= 1'b1;
        s_bresp     <= slv_resp;
        aw_got      <= 1'b0;
        w_got       <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_got   <= 1'b1;
          awaddr_l <= bus.awaddr;
        end
        if (w_hs) begin
          w_got   <= 1'b1;
          wdata_l <= bus.wdata;
          wstrb_l <= bus.wstrb;
        end
      end
      if (s_bvalid && bus.bready) s_bvalid <= 1'b0;
    end
  end

  // Per-transaction handshake counts and a flag for bready raised too early.
  logic mon_clr;
  int   aw_cnt, w_cnt;
  logic b_early;

  always @(posedge aclk) begin
    if (mon_clr) begin
      aw_cnt  <= 0;
      w_cnt   <= 0;
      b_early <= 1'b0;
    end else begin
      if (aw_hs) aw_cnt <= aw_cnt + 1;
      if (w_hs)  w_cnt  <= w_cnt + 1;
      if (bus.bready && (aw_cnt == 0 || w_cnt == 0)) b_early <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
    int n;
    @(negedge aclk);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = strb;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(output int cycles);
    cycles = 0;
    do begin
      @(negedge aclk);
      cycles++;
    end while (!rsp_valid && cycles < 100);
    checkOutput("rsp_arrived", rsp_valid, 1);
  endtask

  task automatic takeRsp();
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1;
    rsp_ready = 1'b0;
    @(negedge aclk);
    checkOutput("idle_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] held;
    areset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b0;
    aw_rdy    = 1'b1;
    w_rdy     = 1'b1;
    ar_rdy    = 1'b1;
    slv_resp  = RESP_OKAY;
    mon_clr   = 1'b1;
    repeat (3) @(negedge aclk);
    checkOutput("rst_awvalid", bus.awvalid, 0);
    checkOutput("rst_wvalid", bus.wvalid, 0);
    checkOutput("rst_arvalid", bus.arvalid, 0);
    checkOutput("rst_bready", bus.bready, 0);
    checkOutput("rst_rready", bus.rready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_resp", rsp_resp, RESP_OKAY);
    checkOutput("rst_timeout", timeout_o, 0);
    areset_n = 1'b1;
    mon_clr  = 1'b0;
    @(negedge aclk);
    checkOutput("rst_cmd_ready", cmd_ready, 1);

    $display("[TB] write then read back 0x4");
    applyStimulus(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    waitRsp(lat);
    checkOutput("wr_latency", lat, 3);
    checkOutput("wr_rsp_write", rsp_write, 1);
    checkOutput("wr_rsp_rdata", rsp_rdata, 0);
    checkOutput("wr_rsp_resp", rsp_resp, RESP_OKAY);
    takeRsp();
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0);
    waitRsp(lat);
    checkOutput("rd_latency", lat, 3);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    checkOutput("rd_rsp_resp", rsp_resp, RESP_OKAY);
    checkOutput("rd_rsp_write", rsp_write, 0);
    takeRsp();

    $display("[TB] partial strobe merge at 0x8");
    applyStimulus(1'b1, 32'h8, 32'h11223344, 4'hF);
    waitRsp(lat);
    takeRsp();
    applyStimulus(1'b1, 32'h8, 32'hAABBCCDD, 4'h5);
    waitRsp(lat);
    takeRsp();
    applyStimulus(1'b0, 32'h8, 32'h0, 4'h0);
    waitRsp(lat);
    checkOutput("strb_rdata", rsp_rdata, 32'h11BB33DD);

    $display("[TB] response backpressure");
    held = rsp_rdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_rdata", rsp_rdata, 32'h11BB33DD);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
    end
    checkOutput("hold_rdata_stable", rsp_rdata, held);
    takeRsp();

    $display("[TB] error response passes through");
    slv_resp = RESP_SLVERR;
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0);
    waitRsp(lat);
    checkOutput("slverr_resp", rsp_resp, RESP_SLVERR);
    checkOutput("slverr_rdata", rsp_rdata, 32'hDEADBEEF);
    takeRsp();
    slv_resp = RESP_DECERR;
    applyStimulus(1'b1, 32'h10, 32'h0, 4'h0);
    waitRsp(lat);
    checkOutput("decerr_resp", rsp_resp, RESP_DECERR);
    takeRsp();
    slv_resp = RESP_OKAY;

    $display("[TB] AW accepted before W");
    mon_clr = 1'b1;
    @(negedge aclk);
    mon_clr = 1'b0;
    aw_rdy  = 1'b1;
    w_rdy   = 1'b0;
    applyStimulus(1'b1, 32'hC, 32'h0BADF00D, 4'hF);
    repeat (5) @(negedge aclk);
    checkOutput("awfirst_awvalid", bus.awvalid, 0);
    checkOutput("awfirst_wvalid", bus.wvalid, 1);
    checkOutput("awfirst_bready", bus.bready, 0);
    w_rdy = 1'b1;
    waitRsp(lat);
    checkOutput("awfirst_aw_cnt", aw_cnt, 1);
    checkOutput("awfirst_w_cnt", w_cnt, 1);
    checkOutput("awfirst_b_early", b_early, 0);
    checkOutput("awfirst_resp", rsp_resp, RESP_OKAY);
    takeRsp();

    $display("[TB] W accepted before AW");
    mon_clr = 1'b1;
    @(negedge aclk);
    mon_clr = 1'b0;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b1;
    applyStimulus(1'b1, 32'hC, 32'hCAFE1234, 4'hF);
    repeat (5) @(negedge aclk);
    checkOutput("wfirst_awvalid", bus.awvalid, 1);
    checkOutput("wfirst_wvalid", bus.wvalid, 0);
    checkOutput("wfirst_bready", bus.bready, 0);
    aw_rdy = 1'b1;
    waitRsp(lat);
    checkOutput("wfirst_aw_cnt", aw_cnt, 1);
    checkOutput("wfirst_w_cnt", w_cnt, 1);
    checkOutput("wfirst_b_early", b_early, 0);
    checkOutput("wfirst_resp", rsp_resp, RESP_OKAY);
    takeRsp();
    applyStimulus(1'b0, 32'hC, 32'h0, 4'h0);
    waitRsp(lat);
    checkOutput("wfirst_readback", rsp_rdata, 32'hCAFE1234);
    takeRsp();

    $display("[TB] stalled AR channel watchdog");
    ar_rdy = 1'b0;
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0);
    repeat (16) @(negedge aclk);
    checkOutput("to_before_limit", timeout_o, 0);
    @(negedge aclk);
    checkOutput("to_at_limit", timeout_o, 1);
    checkOutput("to_arvalid_held", bus.arvalid, 1);
    repeat (4) @(negedge aclk);
    checkOutput("to_sticky", timeout_o, 1);
    checkOutput("to_arvalid_still", bus.arvalid, 1);
    ar_rdy = 1'b1;
    waitRsp(lat);
    checkOutput("to_rdata", rsp_rdata, 32'hDEADBEEF);
    checkOutput("to_kept_in_rsp", timeout_o, 1);
    takeRsp();
    checkOutput("to_kept_in_idle", timeout_o, 1);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'h0);
    checkOutput("to_cleared_on_accept", timeout_o, 0);
    waitRsp(lat);
    takeRsp();

    $display("[TB] reset during write");
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    applyStimulus(1'b1, 32'h4, 32'h12345678, 4'hF);
    @(negedge aclk);
    checkOutput("mid_awvalid_before", bus.awvalid, 1);
    areset_n = 1'b0;
    @(negedge aclk);
    checkOutput("mid_awvalid", bus.awvalid, 0);
    checkOutput("mid_wvalid", bus.wvalid, 0);
    checkOutput("mid_arvalid", bus.arvalid, 0);
    checkOutput("mid_bready", bus.bready, 0);
    checkOutput("mid_rsp_valid", rsp_valid, 0);
    areset_n = 1'b1;
    aw_rdy   = 1'b1;
    w_rdy    = 1'b1;
    @(negedge aclk);
    checkOutput("mid_cmd_ready", cmd_ready, 1);
    checkOutput("mid_rsp_valid_after", rsp_valid, 0);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0);
    waitRsp(lat);
    checkOutput("mid_write_dropped", rsp_rdata, 32'hDEADBEEF);
    takeRsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
